// File: rtl/rtc_pkg.sv
// Shared RTC types: time-of-day struct used on rtc ports and the timestamp entry
// layout (default 16-bit sequence) queued by rtc_tsu.
package rtc_pkg;
  localparam int RTC_SEC_W     = 48;
  localparam int RTC_NS_W      = 38;
  localparam int RTC_TSU_SEQ_W = 16;

  typedef struct packed {
    logic [RTC_SEC_W-1:0] sec;
    logic [RTC_NS_W-1:0]  ns;
  } rtc_time_t;

  typedef struct packed {
    rtc_time_t                tod;
    logic [RTC_TSU_SEQ_W-1:0] seq;
  } rtc_tsu_entry_t;
endpackage

// File: rtl/rtc_tsu_fifo.sv
// Generic synchronous FIFO; head is muxed straight from registered storage so it
// stays stable until popped. Pointers carry one extra wrap bit for full/empty.
module rtc_tsu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  // When full, the slot being written is the one retired by the same-cycle pop.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end
endmodule

// File: rtl/rtc_tsu.sv
// Timestamp capture unit: rising evt_in edges snapshot the RTC ToD plus a sequence
// number into a FIFO drained over valid/ready. RTC_TSU_SYNC_EN adds a 2-flop synchronizer.
module rtc_tsu
  import rtc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [RTC_NS_W-1:0]     time_reg_ns,
  input  logic [RTC_SEC_W-1:0]    time_reg_sec,
  input  logic                    evt_in,
  input  logic                    evt_en,
  output logic                    ts_valid,
  input  logic                    ts_ready,
  output logic [RTC_SEC_W-1:0]    ts_sec,
  output logic [RTC_NS_W-1:0]     ts_ns,
  output logic [SEQ_W-1:0]        ts_seq,
  output logic                    ovf,
  input  logic                    ovf_clr,
  output logic [7:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]  level
);
  // Handshake: an entry moves when ts_valid & ts_ready at a rising clk edge;
  // ts_valid never drops and the head never changes while waiting for ts_ready.
  typedef struct packed {
    rtc_time_t        tod;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic evt_c, pipe_full;

`ifdef RTC_TSU_SYNC_EN
  logic       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0] fill_q, fill_d;

  always_comb begin
    sync1_d = evt_in;
    sync2_d = sync1_q;
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill_q  <= 2'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      fill_q  <= fill_d;
    end
  end

  assign evt_c     = sync2_q;
  assign pipe_full = (fill_q == 2'd2);
`else
  assign evt_c     = evt_in;
  assign pipe_full = 1'b1;
`endif

  logic             evt_q, evt_d, arm_q, arm_d, ovf_q, ovf_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             evt_pulse, pop, full, empty, drop;
  entry_t           wr_entry, head;

  // arm_q stays low until a genuine low level has been seen after reset, so an
  // input already high at reset release is not taken as an edge.
  assign evt_pulse = evt_c & ~evt_q & evt_en & arm_q;
  assign pop       = ts_valid & ts_ready;
  assign drop      = evt_pulse & full & ~pop;
  assign wr_entry  = '{tod: '{sec: time_reg_sec, ns: time_reg_ns}, seq: seq_q};

  always_comb begin
    evt_d      = evt_c;
    arm_d      = arm_q | (pipe_full & ~evt_c);
    seq_d      = evt_pulse ? seq_q + 1'b1 : seq_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = ovf_clr ? 8'd1 : ((drop_cnt_q == 8'hFF) ? 8'hFF : drop_cnt_q + 8'd1);
    end else if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q      <= 1'b0;
      arm_q      <= 1'b0;
      seq_q      <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      evt_q      <= evt_d;
      arm_q      <= arm_d;
      seq_q      <= seq_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  rtc_tsu_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (evt_pulse),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign ts_valid = ~empty;
  assign ts_sec   = head.tod.sec;
  assign ts_ns    = head.tod.ns;
  assign ts_seq   = head.seq;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_rtc_tsu.sv
// Bench for rtc_tsu: queue-based reference model checked every cycle plus directed
// scenarios with literal expectations. Honours RTC_TSU_SYNC_EN for capture latency.
module tb_rtc_tsu;
  import rtc_pkg::*;

  localparam int DEPTH = 4;
  localparam int SW    = 4;   // narrow sequence so wrap-around is reachable quickly
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef RTC_TSU_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif
  localparam logic [29:0] NS_WRAP = 30'd1_000_000_000;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          evt_in = 1'b0, evt_en = 1'b1, ts_ready = 1'b0, ovf_clr = 1'b0;
  logic [47:0]   time_reg_sec = '0;
  logic [37:0]   time_reg_ns  = '0;
  logic          ts_valid, ovf;
  logic [47:0]   ts_sec;
  logic [37:0]   ts_ns;
  logic [SW-1:0] ts_seq;
  logic [7:0]    drop_cnt;
  logic [LW-1:0] level;
  bit            rtc_run = 1'b0;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  rtc_tsu #(.DEPTH(DEPTH), .SEQ_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .time_reg_ns(time_reg_ns), .time_reg_sec(time_reg_sec),
    .evt_in(evt_in), .evt_en(evt_en), .ts_valid(ts_valid), .ts_ready(ts_ready),
    .ts_sec(ts_sec), .ts_ns(ts_ns), .ts_seq(ts_seq), .ovf(ovf), .ovf_clr(ovf_clr),
    .drop_cnt(drop_cnt), .level(level)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [47:0] sec;
    logic [37:0] ns;
    int          seq;
  } ment_t;

  ment_t mq[$];
  bit    hist[$];
  int    m_seq = 0, m_drop = 0;
  bit    m_ovf = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", ts_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_sec", ts_sec, 0);
      chk("rst_ns", ts_ns, 0);
      chk("rst_seq", ts_seq, 0);
      mq.delete();
      hist.delete();
      m_seq = 0; m_drop = 0; m_ovf = 1'b0;
    end else begin
      int  c;
      bit  pulse, pop;
      chk("m_valid", ts_valid, mq.size() > 0);
      chk("m_level", level, mq.size());
      chk("m_ovf", ovf, m_ovf);
      chk("m_drop", drop_cnt, m_drop);
      if (mq.size() > 0) begin
        chk("m_sec", ts_sec, mq[0].sec);
        chk("m_ns", ts_ns, mq[0].ns);
        chk("m_seq", ts_seq, mq[0].seq);
      end
      // Advance the model across the coming edge.
      hist.push_back(evt_in);
      c     = hist.size() - 1;
      pulse = evt_en && (c - L - 1 >= 0) && hist[c-L] && !hist[c-L-1];
      pop   = (mq.size() > 0) && ts_ready;
      if (pop) void'(mq.pop_front());
      if (pulse && mq.size() < DEPTH) begin
        mq.push_back('{sec: time_reg_sec, ns: time_reg_ns, seq: m_seq});
        if (ovf_clr) begin m_ovf = 1'b0; m_drop = 0; end
      end else if (pulse) begin
        m_ovf  = 1'b1;
        m_drop = ovf_clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
      end else if (ovf_clr) begin
        m_ovf = 1'b0; m_drop = 0;
      end
      if (pulse) m_seq = (m_seq + 1) % (1 << SW);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rtc_run) begin
      if (time_reg_ns[37:8] + 30'd8 >= NS_WRAP) begin
        time_reg_ns[37:8] = time_reg_ns[37:8] + 30'd8 - NS_WRAP;
        time_reg_sec      = time_reg_sec + 48'd1;
      end else begin
        time_reg_ns[37:8] = time_reg_ns[37:8] + 30'd8;
      end
    end
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  // One event; clr/rdy are applied in exactly the cycle the capture pulse occurs.
  task automatic evt_with(input bit clr, input bit rdy);
    evt_in = 1'b1;
    for (int i = 0; i < L; i++) begin
      tick();
      evt_in = 1'b0;
    end
    ovf_clr  = clr;
    ts_ready = rdy;
    tick();
    ovf_clr  = 1'b0;
    ts_ready = 1'b0;
    evt_in   = 1'b0;
    tick();
  endtask

  task automatic wait_valid(input string name);
    int i = 0;
    while (!ts_valid && i < 16) begin
      tick();
      i++;
    end
    chk(name, ts_valid, 1);
  endtask

  int           got_seq[$];
  logic [85:0]  got_t[$];

  task automatic drain();
    got_seq.delete();
    got_t.delete();
    ts_ready = 1'b1;
    for (int i = 0; i < 40 && ts_valid; i++) begin
      got_seq.push_back(int'(ts_seq));
      got_t.push_back({ts_sec, ts_ns});
      tick();
    end
    ts_ready = 1'b0;
    chk("drain_done", ts_valid, 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [85:0] head_t;
    evt_in = 1'b1;  // held high through reset release
    settle(3);
    chk("reset_valid", ts_valid, 0);
    chk("reset_level", level, 0);
    rst_n = 1'b1;
    settle(6);
    chk("hi_at_release_level", level, 0);
    chk("hi_at_release_head", ts_seq, 0);
    evt_in = 1'b0;
    settle(L + 2);

    // Single capture with a frozen RTC value.
    time_reg_sec = 48'h5;
    time_reg_ns  = 38'h1000;
    evt_with(1'b0, 1'b0);
    wait_valid("single_valid");
    chk("single_sec", ts_sec, 48'h5);
    chk("single_ns", ts_ns, 38'h1000);
    chk("single_seq", ts_seq, 0);
    settle(3);
    chk("single_hold", ts_valid, 1);
    drain();
    chk("single_count", got_seq.size(), 1);

    // Disabled edge: no entry and no sequence step.
    evt_en = 1'b0;
    evt_with(1'b0, 1'b0);
    settle(4);
    chk("en0_level", level, 0);
    evt_en = 1'b1;

    // Backpressure with the RTC counting.
    rtc_run = 1'b1;
    repeat (4) evt_with(1'b0, 1'b0);
    settle(L + 2);
    chk("bp_level", level, 4);
    chk("bp_head_seq", ts_seq, 1);
    head_t = {ts_sec, ts_ns};
    settle(3);
    chk("bp_head_stable", ({ts_sec, ts_ns} == head_t), 1);
    drain();
    chk("bp_count", got_seq.size(), 4);
    for (int i = 0; i < 4 && i < got_seq.size(); i++) chk("bp_seq_order", got_seq[i], 1 + i);
    for (int i = 1; i < got_t.size(); i++) chk("bp_time_incr", (got_t[i] > got_t[i-1]), 1);

    // Overflow: 6 events into 4 slots.
    repeat (6) evt_with(1'b0, 1'b0);
    settle(L + 2);
    chk("ovf_level", level, 4);
    chk("ovf_flag", ovf, 1);
    chk("ovf_drop", drop_cnt, 2);
    drain();
    chk("ovf_first_seq", (got_seq.size() > 0) ? got_seq[0] : -1, 5);
    evt_with(1'b0, 1'b0);
    wait_valid("ovf_next_valid");
    chk("ovf_next_seq_gap", ts_seq, 11);
    drain();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr_flag", ovf, 0);
    chk("ovf_clr_drop", drop_cnt, 0);

    // Full FIFO with push and pop in the same cycle; sequence wraps 15 -> 0.
    repeat (4) evt_with(1'b0, 1'b0);
    settle(L + 2);
    chk("fullpp_pre_level", level, 4);
    evt_with(1'b0, 1'b1);
    settle(L + 2);
    chk("fullpp_level", level, 4);
    chk("fullpp_ovf", ovf, 0);
    chk("fullpp_head", ts_seq, 13);
    drain();
    chk("wrap_count", got_seq.size(), 4);
    if (got_seq.size() == 4) begin
      chk("wrap_seq_f", got_seq[2], 15);
      chk("wrap_seq_0", got_seq[3], 0);
    end

    // Drop coincident with ovf_clr: the drop wins.
    repeat (4) evt_with(1'b0, 1'b0);
    repeat (2) evt_with(1'b0, 1'b0);
    settle(L + 2);
    chk("clrdrop_pre", drop_cnt, 2);
    evt_with(1'b1, 1'b0);
    settle(L + 2);
    chk("clrdrop_ovf", ovf, 1);
    chk("clrdrop_cnt", drop_cnt, 1);
    drain();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Second rollover on the capture cycle.
    time_reg_sec = 48'h1234;
    time_reg_ns  = {NS_WRAP - 30'd8 - 30'(8 * L), 8'h5A};
    tick();
    evt_with(1'b0, 1'b0);
    wait_valid("roll_valid");
    chk("roll_sec", ts_sec, 48'h1235);
    chk("roll_ns", ts_ns, 38'h5A);
    chk("roll_seq", ts_seq, 8);
    drain();

    // Reset mid-operation flushes entries and restarts the sequence.
    repeat (2) evt_with(1'b0, 1'b0);
    settle(L + 2);
    chk("midrst_pre_level", level, 2);
    rst_n = 1'b0;
    tick();
    chk("midrst_level", level, 0);
    chk("midrst_valid", ts_valid, 0);
    tick();
    rst_n = 1'b1;
    settle(L + 2);
    evt_with(1'b0, 1'b0);
    wait_valid("midrst_valid_after");
    chk("midrst_seq", ts_seq, 0);
    drain();

    // Drop counter saturation.
    repeat (4) evt_with(1'b0, 1'b0);
    repeat (258) evt_with(1'b0, 1'b0);
    settle(L + 2);
    chk("sat_drop", drop_cnt, 255);
    drain();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("sat_clr", drop_cnt, 0);
    settle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rtc_tsu.md
# rtc_tsu

Timestamp capture unit: the reader of the RTC time bus. On each rising edge of an event input it samples the running ToD (`time_reg_sec`, `time_reg_ns`), tags it with a sequence number and queues it in a small FIFO. Host or PTP logic drains entries through a valid/ready port. It sits beside `rtc`, fed directly from the RTC time outputs, and serves PPS-in, SFD-detect and GPIO event timestamping.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `SEQ_W`, 16: sequence counter width.
- `clk`  in  1: RTC clock, same clock as `rtc`.
- `rst_n`  in  1: asynchronous, active-low reset.
- `time_reg_ns`  in  38: RTC ns (37:8) and ns_fraction (7:0).
- `time_reg_sec`  in  48: RTC seconds.
- `evt_in`  in  1: event input; rising edge triggers capture.
- `evt_en`  in  1: capture enable; edges are ignored while low.
- `ts_valid`  out  1: head entry available.
- `ts_ready`  in  1: consumer accepts head entry.
- `ts_sec`  out  48: head entry seconds.
- `ts_ns`  out  38: head entry ns and fraction.
- `ts_seq`  out  SEQ_W: head entry sequence number.
- `ovf`  out  1: sticky; an event was dropped because the FIFO was full.
- `ovf_clr`  in  1: clears `ovf`.
- `drop_cnt`  out  8: dropped-event count; saturates at 255; cleared by `ovf_clr`.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Edge detect: `evt_q` holds the previous sample of the conditioned event. `evt_pulse = evt_c & ~evt_q & evt_en`.
- Capture: in a cycle with `evt_pulse` high, the current `time_reg_sec`/`time_reg_ns` and the current `seq` form one entry. `seq` increments modulo 2^SEQ_W on every pulse, including dropped ones, so gaps in `ts_seq` reveal drops.
- Push is accepted when not full, or when full with a simultaneous pop (`ts_valid & ts_ready`). Otherwise the event is dropped: `ovf` is set and `drop_cnt` increments, saturating.
- Pop: when `ts_valid & ts_ready`, the head entry is retired. The head outputs are read from registers and are held stable while `ts_valid & ~ts_ready`.
- `ovf_clr` coincident with a drop: the drop wins, so `ovf` = 1 and `drop_cnt` = 1.
- Pointers wrap modulo DEPTH. Full/empty are taken from an extra pointer bit.
- Reset values:
  - `ts_valid` = 0, `ovf` = 0, `drop_cnt` = 0, `level` = 0, `seq` = 0, `evt_q` = 0.
  - `ts_sec`, `ts_ns` and `ts_seq` = 0.
  - Synchronizer flops = 0.
- Reset asserted mid-operation flushes all entries. A high `evt_in` at reset release is not an edge.

## Timing
- With `RTC_TSU_SYNC_EN`: `evt_in` rises before posedge N.
  - `evt_pulse` is high in cycle N+2.
  - The captured time is the RTC value during cycle N+2, i.e. the value registered at edge N+2.
  - `ts_valid` rises in cycle N+3 if the FIFO was empty.
- Without the macro: `evt_pulse` is high in cycle N and `ts_valid` rises in N+1.
- Empty-to-valid latency is 1 cycle after the push. `ts_valid` falls in the cycle after the last pop.
- Back-to-back events on consecutive edge pulses each capture. The minimum event spacing is 2 cycles, because high and low must each be sampled.
- Throughput: 1 push and 1 pop per cycle.

## Configuration
- `RTC_TSU_SYNC_EN` defined:
  - A two-flop synchronizer, reset to 0, drives `evt_c`.
  - `evt_in` may be fully asynchronous.
  - Capture latency is fixed at 2 cycles. Software subtracts 2 × period.
- Undefined: `evt_c = evt_in` directly. `evt_in` must be synchronous to `clk`. Capture latency is 0.

## Structure
- Shared package `rtc_pkg`:
  - `RTC_SEC_W` = 48, `RTC_NS_W` = 38.
  - `rtc_time_t` packed struct {sec, ns}, also reused by `rtc` ports.
  - `rtc_tsu_entry_t` {time, seq}.
- Sub-module `rtc_tsu_fifo`: a generic synchronous FIFO with DEPTH and WIDTH parameters, registered head output, and full/empty/level. Edge detect, sequencing and overflow logic stay in `rtc_tsu`.

## Test plan
- Single capture: RTC counting with sec = 0x5, ns = 0x1000; pulse `evt_in` → one entry with the RTC value from the capture cycle; `ts_seq` = 0; `ts_valid` high until `ts_ready`.
- Backpressure: 4 events, `ts_ready` = 0 → `level` = 4, head stable; then drain with `ts_ready` = 1 → seq 0, 1, 2, 3 in order; captured times strictly increasing.
- Overflow: DEPTH = 4, 6 events, no pop → `ovf` = 1, `drop_cnt` = 2; next accepted entry has `ts_seq` = 6; `ovf_clr` → `ovf` = 0, `drop_cnt` = 0.
- Full with simultaneous pop and push → push accepted, `level` stays 4, `ovf` stays 0.
- `evt_en` = 0 during an edge → no entry and `seq` unchanged. `evt_in` held high through `rst_n` release → no capture.
- Second rollover: ns near `time_acc_modulo`, event lands on the wrap cycle → entry has sec + 1 and the wrapped ns. Sequence counter: force `seq` = 0xFFFF → next entries 0xFFFF, 0x0000.
